// File: rtl/mem_dump_reader_if.sv
// Bundle of the memory read port, the UART byte handshake and the dump control
// signals shared between mem_dump_reader (master) and its environment (slave).
interface mem_dump_reader_if #(
    parameter int len_data = 32,
    parameter int addr_w   = 6
);
    logic                start;
    logic [addr_w-1:0]   Addr;
    logic                Rd;
    logic [len_data-1:0] Out_Data;
    logic [7:0]          tx_data;
    logic                tx_start;
    logic                tx_done;
    logic                busy;
    logic                done;

    modport master (
        input  start, Out_Data, tx_done,
        output Addr, Rd, tx_data, tx_start, busy, done
    );

    modport slave (
        output start, Out_Data, tx_done,
        input  Addr, Rd, tx_data, tx_start, busy, done
    );
endinterface

// File: rtl/mem_dump_reader.sv
// Streams every word of the data memory out through a byte-wide UART,
// most-significant byte first, one read and one byte handshake at a time.
module mem_dump_reader #(
    parameter int len_data  = 32,
    parameter int ram_depth = 64
) (
    input  logic              clk,
    input  logic              reset,
    mem_dump_reader_if.master bus
);
    // Number of bits needed to hold the given value.
    function automatic int clogb2(input int value);
        int result;
        int v;
        result = 0;
        v      = value;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    localparam int addr_w  = clogb2(ram_depth - 1);
    localparam int n_bytes = len_data / 8;
    localparam int cnt_w   = (n_bytes > 1) ? clogb2(n_bytes - 1) : 1;

    localparam logic [addr_w-1:0] last_addr = addr_w'(ram_depth - 1);
    localparam logic [cnt_w-1:0]  last_byte = cnt_w'(n_bytes - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        SEND,
        WAIT_TX,
        NEXT,
        FIN
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [addr_w-1:0]   addr_q;
    logic [len_data-1:0] word_q;
    logic [cnt_w-1:0]    byte_cnt;
    logic [7:0]          word_bytes [n_bytes];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // tx_done is only honoured in WAIT_TX, so one arriving alongside tx_start is ignored.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = READ;
            READ:    next_state = CAPTURE;
            CAPTURE: next_state = SEND;
            SEND:    next_state = WAIT_TX;
            WAIT_TX: begin
                if (bus.tx_done) begin
                    next_state = (byte_cnt == last_byte) ? NEXT : SEND;
                end
            end
            NEXT:    next_state = (addr_q == last_addr) ? FIN : READ;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            word_q   <= '0;
            byte_cnt <= '0;
        end else begin
            case (state)
                IDLE:    if (bus.start) addr_q <= '0;
                CAPTURE: begin
                    word_q   <= bus.Out_Data;
                    byte_cnt <= '0;
                end
                WAIT_TX: begin
                    if (bus.tx_done && (byte_cnt != last_byte)) begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                NEXT:    if (addr_q != last_addr) addr_q <= addr_q + 1'b1;
                FIN:     addr_q <= '0;
                default: ;
            endcase
        end
    end

    // Byte 0 is the most significant byte of the captured word.
    always_comb begin
        for (int i = 0; i < n_bytes; i++) begin
            word_bytes[i] = word_q[len_data-1-8*i -: 8];
        end
    end

    assign bus.tx_data  = word_bytes[byte_cnt];
    assign bus.Addr     = addr_q;
    assign bus.Rd       = (state == READ);
    assign bus.tx_start = (state == SEND);
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == FIN);
endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: a 4-word memory model, a UART model
// acknowledging each byte 5 cycles after tx_start, and a byte-stream reference.
module tb_mem_dump_reader;
    localparam int len_data  = 32;
    localparam int ram_depth = 4;
    localparam int addr_w    = 2;
    localparam int n_bytes   = len_data / 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        uart_done;
    logic        inject_done;
    logic        uart_enable;
    int          uart_cnt;
    logic [31:0] mem [ram_depth];
    logic [7:0]  tx_q [$];
    logic [1:0]  rd_q [$];
    logic [7:0]  exp_bytes [$];
    int          overlap_cnt = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    mem_dump_reader_if #(.len_data(len_data), .addr_w(addr_w)) bus ();

    mem_dump_reader #(.len_data(len_data), .ram_depth(ram_depth)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.tx_done = uart_done | inject_done;

    always @(posedge clk) begin
        if (bus.Rd) bus.Out_Data <= mem[bus.Addr];
    end

    // UART model: one acknowledge pulse five cycles after each accepted tx_start.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            uart_cnt  <= 0;
            uart_done <= 1'b0;
        end else begin
            uart_done <= 1'b0;
            if (uart_cnt > 0) begin
                uart_cnt <= uart_cnt - 1;
                if (uart_cnt == 1) uart_done <= 1'b1;
            end
            if (bus.tx_start && uart_enable) uart_cnt <= 5;
        end
    end

    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) tx_q.push_back(bus.tx_data);
        if (bus.Rd === 1'b1) rd_q.push_back(bus.Addr);
        if (bus.tx_start === 1'b1 && bus.done === 1'b1) overlap_cnt++;
    end

    // Reference stream: every word, most significant byte first.
    function automatic void build_expected();
        exp_bytes.delete();
        for (int w = 0; w < ram_depth; w++) begin
            for (int b = 0; b < n_bytes; b++) begin
                exp_bytes.push_back(8'((mem[w] >> (8 * (n_bytes - 1 - b))) & 32'hFF));
            end
        end
    endfunction

    task automatic clear_logs();
        tx_q.delete();
        rd_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.Addr !== 2'd0) $display("[TB] FAIL reset Addr: got %0h, required 0", bus.Addr); else n_pass++;
        n_checks++; if (bus.Rd !== 1'b0) $display("[TB] FAIL reset Rd: got %b, required 0", bus.Rd); else n_pass++;
        n_checks++; if (bus.tx_data !== 8'h00) $display("[TB] FAIL reset tx_data: got %02h, required 00", bus.tx_data); else n_pass++;
        n_checks++; if (bus.tx_start !== 1'b0) $display("[TB] FAIL reset tx_start: got %b, required 0", bus.tx_start); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset busy: got %b, required 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("[TB] FAIL reset done: got %b, required 0", bus.done); else n_pass++;
        bus.start = 1'b0;
        @(negedge clk) reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset idle_after_release busy: got %b, required 0", bus.busy); else n_pass++;
    endtask

    task automatic test_full_dump();
        bit got;
        clear_logs();
        build_expected();
        pulse_start();
        n_checks++; if (bus.Rd !== 1'b1 || bus.Addr !== 2'd0) $display("[TB] FAIL latency N+1 Rd/Addr: got %b/%0h, required 1/0", bus.Rd, bus.Addr); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.tx_start !== 1'b0) $display("[TB] FAIL latency N+2 tx_start: got %b, required 0", bus.tx_start); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h11) $display("[TB] FAIL latency N+3 tx_start/tx_data: got %b/%02h, required 1/11", bus.tx_start, bus.tx_data); else n_pass++;
        wait_done(1000, got);
        n_checks++; if (got !== 1'b1) $display("[TB] FAIL full_dump done seen: got %b, required 1", got); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("[TB] FAIL full_dump after done done/busy: got %b/%b, required 0/0", bus.done, bus.busy); else n_pass++;
        n_checks++; if (tx_q.size() !== exp_bytes.size()) $display("[TB] FAIL full_dump tx_start count: got %0d, required %0d", tx_q.size(), exp_bytes.size()); else n_pass++;
        for (int i = 0; i < exp_bytes.size(); i++) begin
            n_checks++;
            if (i >= tx_q.size() || tx_q[i] !== exp_bytes[i]) $display("[TB] FAIL full_dump byte %0d: got %02h, required %02h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_bytes[i]); else n_pass++;
        end
        n_checks++; if (rd_q.size() !== ram_depth) $display("[TB] FAIL full_dump Rd count: got %0d, required %0d", rd_q.size(), ram_depth); else n_pass++;
        for (int i = 0; i < rd_q.size() && i < ram_depth; i++) begin
            n_checks++; if (rd_q[i] !== 2'(i)) $display("[TB] FAIL full_dump Rd addr %0d: got %0h, required %0h", i, rd_q[i], i); else n_pass++;
        end
    endtask

    task automatic test_busy_ignore_spurious();
        bit got;
        clear_logs();
        build_expected();
        pulse_start();
        got = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got = 1'b1;
                break;
            end
            inject_done = (bus.Rd === 1'b1) && (bus.Addr === 2'd1);
            bus.start = (tx_q.size() < 12) && ($urandom_range(7) == 0);
        end
        bus.start = 1'b0;
        inject_done = 1'b0;
        n_checks++; if (got !== 1'b1) $display("[TB] FAIL busy_ignore done seen: got %b, required 1", got); else n_pass++;
        repeat (20) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL busy_ignore no restart busy: got %b, required 0", bus.busy); else n_pass++;
        n_checks++; if (tx_q.size() !== exp_bytes.size()) $display("[TB] FAIL busy_ignore tx_start count: got %0d, required %0d", tx_q.size(), exp_bytes.size()); else n_pass++;
        for (int i = 0; i < exp_bytes.size(); i++) begin
            n_checks++;
            if (i >= tx_q.size() || tx_q[i] !== exp_bytes[i]) $display("[TB] FAIL busy_ignore byte %0d: got %02h, required %02h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_bytes[i]); else n_pass++;
        end
        n_checks++; if (rd_q.size() !== ram_depth) $display("[TB] FAIL busy_ignore Rd count: got %0d, required %0d", rd_q.size(), ram_depth); else n_pass++;
    endtask

    task automatic test_reset_mid_dump();
        bit found;
        bit got;
        int sz;
        clear_logs();
        build_expected();
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (bus.tx_start === 1'b1 && bus.tx_data === 8'hBB) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++; if (found !== 1'b1) $display("[TB] FAIL reset_mid reached BB: got %b, required 1", found); else n_pass++;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        n_checks++; if ({bus.Addr, bus.Rd, bus.tx_data, bus.tx_start, bus.busy, bus.done} !== 14'd0)
            $display("[TB] FAIL reset_mid outputs Addr/Rd/tx_data/tx_start/busy/done: got %0h/%b/%02h/%b/%b/%b, required all 0", bus.Addr, bus.Rd, bus.tx_data, bus.tx_start, bus.busy, bus.done);
        else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sz = tx_q.size();
        repeat (30) @(negedge clk);
        n_checks++; if (tx_q.size() !== sz || bus.busy !== 1'b0) $display("[TB] FAIL reset_mid quiet after release tx_count/busy: got %0d/%b, required %0d/0", tx_q.size(), bus.busy, sz); else n_pass++;
        clear_logs();
        pulse_start();
        n_checks++; if (bus.Rd !== 1'b1 || bus.Addr !== 2'd0) $display("[TB] FAIL reset_mid restart Rd/Addr: got %b/%0h, required 1/0", bus.Rd, bus.Addr); else n_pass++;
        wait_done(1000, got);
        n_checks++; if (got !== 1'b1) $display("[TB] FAIL reset_mid restart done seen: got %b, required 1", got); else n_pass++;
        for (int i = 0; i < exp_bytes.size(); i++) begin
            n_checks++;
            if (i >= tx_q.size() || tx_q[i] !== exp_bytes[i]) $display("[TB] FAIL reset_mid restart byte %0d: got %02h, required %02h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_bytes[i]); else n_pass++;
        end
    endtask

    task automatic test_stall();
        bit found;
        bit got;
        int anomalies;
        clear_logs();
        build_expected();
        uart_enable = 1'b0;
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++; if (found !== 1'b1) $display("[TB] FAIL stall first tx_start: got %b, required 1", found); else n_pass++;
        anomalies = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.busy !== 1'b1 || bus.tx_data !== 8'h11 || bus.tx_start !== 1'b0 || bus.Rd !== 1'b0 || bus.done !== 1'b0) anomalies++;
        end
        n_checks++; if (anomalies !== 0) $display("[TB] FAIL stall held outputs: got %0d bad cycles, required 0", anomalies); else n_pass++;
        n_checks++; if (tx_q.size() !== 1 || rd_q.size() !== 1) $display("[TB] FAIL stall pulse counts tx_start/Rd: got %0d/%0d, required 1/1", tx_q.size(), rd_q.size()); else n_pass++;
        uart_enable = 1'b1;
        inject_done = 1'b1;
        @(negedge clk) inject_done = 1'b0;
        wait_done(1000, got);
        n_checks++; if (got !== 1'b1) $display("[TB] FAIL stall resumed done seen: got %b, required 1", got); else n_pass++;
        for (int i = 0; i < exp_bytes.size(); i++) begin
            n_checks++;
            if (i >= tx_q.size() || tx_q[i] !== exp_bytes[i]) $display("[TB] FAIL stall resumed byte %0d: got %02h, required %02h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_bytes[i]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        bit got;
        clear_logs();
        build_expected();
        pulse_start();
        wait_done(1000, got);
        n_checks++; if (got !== 1'b1) $display("[TB] FAIL back_to_back first done: got %b, required 1", got); else n_pass++;
        clear_logs();
        pulse_start();
        n_checks++; if (bus.Rd !== 1'b1 || bus.Addr !== 2'd0) $display("[TB] FAIL back_to_back restart Rd/Addr: got %b/%0h, required 1/0", bus.Rd, bus.Addr); else n_pass++;
        wait_done(1000, got);
        n_checks++; if (got !== 1'b1) $display("[TB] FAIL back_to_back second done: got %b, required 1", got); else n_pass++;
        n_checks++; if (tx_q.size() !== exp_bytes.size()) $display("[TB] FAIL back_to_back tx_start count: got %0d, required %0d", tx_q.size(), exp_bytes.size()); else n_pass++;
        for (int i = 0; i < exp_bytes.size(); i++) begin
            n_checks++;
            if (i >= tx_q.size() || tx_q[i] !== exp_bytes[i]) $display("[TB] FAIL back_to_back byte %0d: got %02h, required %02h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_bytes[i]); else n_pass++;
        end
        for (int i = 0; i < rd_q.size() && i < ram_depth; i++) begin
            n_checks++; if (rd_q[i] !== 2'(i)) $display("[TB] FAIL back_to_back Rd addr %0d: got %0h, required %0h", i, rd_q[i], i); else n_pass++;
        end
    endtask

    task automatic test_random_content();
        bit got;
        logic [31:0] saved [ram_depth];
        for (int w = 0; w < ram_depth; w++) begin
            saved[w] = mem[w];
            mem[w]   = $urandom;
        end
        clear_logs();
        build_expected();
        pulse_start();
        wait_done(1000, got);
        n_checks++; if (got !== 1'b1) $display("[TB] FAIL random_content done seen: got %b, required 1", got); else n_pass++;
        for (int i = 0; i < exp_bytes.size(); i++) begin
            n_checks++;
            if (i >= tx_q.size() || tx_q[i] !== exp_bytes[i]) $display("[TB] FAIL random_content byte %0d: got %02h, required %02h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_bytes[i]); else n_pass++;
        end
        for (int w = 0; w < ram_depth; w++) mem[w] = saved[w];
    endtask

    task automatic test_no_overlap();
        n_checks++; if (overlap_cnt !== 0) $display("[TB] FAIL done_tx_start_overlap: got %0d cycles, required 0", overlap_cnt); else n_pass++;
    endtask

    initial begin
        reset       = 1'b1;
        inject_done = 1'b0;
        uart_enable = 1'b1;
        bus.start   = 1'b0;
        mem[0] = 32'h11223344;
        mem[1] = 32'hAABBCCDD;
        mem[2] = 32'h00000000;
        mem[3] = 32'hFFFFFFFF;
        test_reset();
        test_full_dump();
        test_busy_ignore_spurious();
        test_reset_mid_dump();
        test_stall();
        test_back_to_back();
        test_random_content();
        test_no_overlap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end
endmodule

// File: doc/mem_dump_reader.md
MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 SHALL have parameter len_data, default 32, data memory word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ram_depth, default 64, number of data memory words dumped per run.
REQ-003 SHALL derive localparam addr_w = clogb2(ram_depth-1), giving 6 for ram_depth 64.
REQ-004 SHALL derive localparam n_bytes = len_data/8.
REQ-005 SHALL have one clock and an asynchronous, active-high reset; no other clock or reset exists.
REQ-006 Port: clk  in  1  system clock; all state changes on its rising edge.
REQ-007 Port: reset  in  1  asynchronous, active-high reset.
REQ-008 Port: start  in  1  request to begin a full memory dump; sampled in IDLE only.
REQ-009 Port: Addr  out  addr_w  word address driven to the data memory.
REQ-010 Port: Rd  out  1  data memory read enable.
REQ-011 Port: Out_Data  in  len_data  data memory read data, valid the cycle after Rd is sampled.
REQ-012 Port: tx_data  out  8  byte presented to the UART transmitter.
REQ-013 Port: tx_start  out  1  single-cycle pulse; UART latches tx_data on it.
REQ-014 Port: tx_done  in  1  single-cycle pulse from the UART when a byte has finished sending.
REQ-015 Port: busy  out  1  high from leaving IDLE until returning to IDLE.
REQ-016 Port: done  out  1  single-cycle pulse when the last byte of the dump is acknowledged.

Function
REQ-017 SHALL be a Moore FSM with states IDLE, READ, CAPTURE, SEND, WAIT_TX, NEXT and FIN; all outputs are registered or state-decoded, with no combinational input-to-output path.
REQ-018 IDLE: if start=1, load Addr=0 and move to READ; otherwise stay.
REQ-019 READ: Rd=1 for exactly one cycle with Addr stable, then move to CAPTURE.
REQ-020 CAPTURE: word register <= Out_Data, byte_cnt <= 0, then move to SEND.
REQ-021 SEND: drive tx_data = word byte byte_cnt, MSB first (byte 0 = word[len_data-1:len_data-8]), and tx_start=1 for this single cycle, then move to WAIT_TX.
REQ-022 WAIT_TX: hold tx_data; on tx_done=1, if byte_cnt == n_bytes-1 move to NEXT, else increment byte_cnt and move to SEND.
REQ-023 NEXT: if Addr == ram_depth-1 move to FIN; else Addr <= Addr+1 and move to READ.
REQ-024 FIN: done=1 for one cycle, Addr <= 0, then move to IDLE.
REQ-025 Cycle timing: start sampled at edge N gives READ in cycle N+1, CAPTURE in N+2, and tx_start high in N+3.
REQ-026 Rd SHALL be 0 in every state except READ; exactly one Rd pulse is issued per word, giving ram_depth Rd pulses per dump.
REQ-027 The block SHALL never write memory; the top level ties the memory Wr to 0 while busy=1.
REQ-028 start while busy=1 SHALL be ignored, with no restart and no queuing.
REQ-029 tx_done outside WAIT_TX SHALL be ignored.
REQ-030 A tx_done coincident with tx_start SHALL NOT count as acknowledgement of the byte being started.
REQ-031 Addr SHALL not wrap inside a dump; the last address read is ram_depth-1.
REQ-032 Total bytes per dump SHALL be ram_depth*n_bytes and total tx_start pulses SHALL equal that number.
REQ-033 done and tx_start SHALL never be high in the same cycle.

Reset
REQ-034 While reset=1, SHALL hold state=IDLE, Addr=0, Rd=0, tx_data=0x00, tx_start=0, busy=0, done=0, word register=0 and byte_cnt=0, independent of clk.
REQ-035 Reset asserted mid-dump SHALL abort immediately with no further tx_start; after release the block waits in IDLE for a fresh start.

Verification
REQ-036 Bench SHALL use ram_depth=4, memory preloaded {0x11223344, 0xAABBCCDD, 0x00000000, 0xFFFFFFFF}, and a UART model returning tx_done 5 cycles after each tx_start; start pulse -> tx_data sequence 11 22 33 44 AA BB CC DD 00 00 00 00 FF FF FF FF, 16 tx_start pulses, 4 Rd pulses at Addr 0,1,2,3, then one done pulse.
REQ-037 Bench SHALL check latency: start at edge N -> Rd=1 with Addr=0 in cycle N+1, and tx_start=1 with tx_data=0x11 in cycle N+3.
REQ-038 Bench SHALL re-pulse start while busy, and inject a spurious tx_done in READ -> byte stream and pulse counts identical to REQ-036.
REQ-039 Bench SHALL assert reset during WAIT_TX of byte 0xBB -> all outputs 0 within the reset cycle, with no further tx_start; a new start then restarts from Addr 0 and byte 0x11.
REQ-040 Bench SHALL hold tx_done low for 1000 cycles in WAIT_TX -> FSM stays in WAIT_TX, tx_data held, busy=1, with no extra tx_start or Rd.
REQ-041 Bench SHALL apply a start one cycle after done -> a second complete identical dump with Addr restarting at 0.
